// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Op codes mirror funct3 of the M-extension instructions.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: shift-add multiply and restoring divide on unsigned
// magnitudes, with sign correction applied once at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_result;

    // Operand decode, valid from PREP onwards (a_q/b_q hold the raw operands there).
    always_comb begin
        is_div   = op_q[2];
        a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                   (op_q == OP_DIV) || (op_q == OP_REM);
        b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        a_neg    = a_signed & a_q[WIDTH-1];
        b_neg    = b_signed & b_q[WIDTH-1];
        mag_a    = a_neg ? -a_q : a_q;
        mag_b    = b_neg ? -b_q : b_q;
        div_zero = is_div && (b_q == '0);
        div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                   (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    end

    // One iteration: product keeps the multiplier in its low half, the quotient
    // shifts in through acc_q's low half while the dividend shifts out.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[WIDTH];
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        case (op_q)
            OP_MUL:                        fix_result = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               fix_result = quot_fix;
            default:                       fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StPrep;
            StPrep:  state_d = (div_zero || div_ovf) ? StDone : StCalc;
            StCalc:  if (cnt_q == '0) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d = op;
                    a_d  = a;
                    b_d  = b;
                end
            end
            StPrep: begin
                neg_d = (is_div && op_q[1]) ? a_neg : (a_neg ^ b_neg);
                b_d   = mag_b;
                acc_d = {{WIDTH{1'b0}}, mag_a};
                rem_d = '0;
                cnt_d = CntW'(WIDTH - 1);
                if (div_zero) begin
                    result_d = op_q[1] ? a_q : '1;
                end else if (div_ovf) begin
                    result_d = op_q[1] ? '0 : a_q;
                end
            end
            StCalc: begin
                cnt_d = cnt_q - 1'b1;
                if (is_div) begin
                    rem_d = div_ge ? div_diff : div_shift;
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            StFix:   result_d = fix_result;
            default: ;
        endcase
    end

    always_comb begin
        stall  = ((state_q == StIdle) && start) || (state_q == StPrep) ||
                 (state_q == StCalc) || (state_q == StFix);
        done   = (state_q == StDone);
        result = result_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench: the driver queues expected result/latency per instruction,
// a negedge monitor pops and checks whenever done is seen.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall, done;
    logic [31:0] result;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, " result"}, result, e.res);
                check({e.name, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // Cycle 0 is the negedge where start is raised; stall must hold until lat.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expv, input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e.name = name;
        e.res  = expv;
        e.lat  = lat;
        e.t0   = cyc;
        sb.push_back(e);
        #1 check({name, " stall c0"}, 32'(stall), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1 check({name, " stall"}, 32'(stall), 32'(k < lat));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        run_op("MUL 7*-3",        OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("MULH min*min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op("MULHU max*max",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op("MULHSU -1*max",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        run_op("DIV -7/2",        OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35);
        run_op("REM -7%2",        OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35);
        run_op("DIVU big/2",      OP_DIVU,   32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 35);
        run_op("REMU big%2",      OP_REMU,   32'hFFFF_FFF9, 32'd2,        32'd1,         35);
        run_op("DIV 5/0",         OP_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 2);
        run_op("REMU 5/0",        OP_REMU,   32'd5,        32'd0,        32'd5,         2);
        run_op("DIV ovf",         OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("REM ovf",         OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
        run_op("DIVU 100/7",      OP_DIVU,   32'd100,      32'd7,        32'd14,        35);

        // Abort a DIVU with reset asserted across the edge ending cycle 10.
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid-reset done", 32'(done), 32'd0);
        check("mid-reset result", result, 32'd0);
        check("mid-reset stall", 32'(stall), 32'd0);

        run_op("MULHU after reset", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 35);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage of the single-cycle core. It sits beside the ALU and takes the same register-file operands. Its result goes to the same writeback mux as the ALU output. While an M-extension instruction is in progress, it holds the core with a stall signal, then presents the result for exactly one cycle.

## Interface
Parameters:
- WIDTH, 32, operand and result width. The only supported value is 32.

Ports:
- clk  in  1  core clock. Everything is sampled on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  decoder asserts this for an M-extension instruction (opcode 0110011, funct7 0000001).
- op  in  3  funct3 of the instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2 operand.
- stall  out  1  freezes PC and register-file writes.
- done  out  1  result valid this cycle; writeback selects result.
- result  out  WIDTH  final value, held stable only while done=1.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE, start=1: latch op, a, b. Go to PREP.
- PREP:
  - Form operand magnitudes from op signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: a signed, b unsigned.
    - All others: unsigned.
  - Record negate_result:
    - Multiply: sign(a) XOR sign(b), counting only signed operands.
    - DIV: same rule.
    - REM: sign(a).
  - Load cnt=31. Go to CALC.
  - Division by zero (b==0, any divide op) goes directly to DONE with result = 0xFFFFFFFF for DIV/DIVU, and result = a for REM/REMU.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) goes directly to DONE with result = 0x80000000 for DIV, 0 for REM.
- CALC: one iteration per cycle. cnt decrements, and the state leaves CALC after the cnt=0 iteration (32 iterations total).
  - Multiply: shift-add into a 64-bit product register (64-bit accumulator).
  - Divide: restoring division, with a 33-bit partial remainder plus a 32-bit quotient register.
- FIX:
  - Apply two's-complement negation where negate_result is set:
    - Multiply: across all 64 bits.
    - DIV: quotient only.
    - REM: remainder only.
  - Select the result:
    - MUL: low 32 bits.
    - MULH, MULHSU, MULHU: high 32 bits.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Go to DONE.
- DONE: done=1, result driven. start is ignored in this cycle (it is the same instruction still being decoded). Go to IDLE.
- stall = (state==IDLE & start) | state==PREP | state==CALC | state==FIX.
- stall is 0 in DONE, so the core writes back and advances the PC that cycle.
- Reset (rst_n=0 at an edge), in any state including mid-CALC:
  - Next state is IDLE.
  - done=0, result=0, cnt=0, internal registers cleared.
  - stall=0 unless start=1.
- All arithmetic is modulo 2^WIDTH. No flags are produced. Signedness comes only from op.

## Timing
- Cycle 0: start sampled while IDLE. stall=1 combinationally.
- Normal path:
  - PREP in cycle 1.
  - CALC in cycles 2–33.
  - FIX in cycle 34.
  - DONE in cycle 35, with done=1.
  - Latency is 35 cycles; the instruction occupies cycles 0–35 (36 cycles).
  - stall=1 in cycles 0–34.
- Fast path (divide-by-zero, overflow): PREP in cycle 1, DONE in cycle 2. stall=1 in cycles 0–1.
- The next start is accepted at the earliest in the cycle after DONE. Back-to-back M-instructions therefore have no bubble beyond the latency.
- result and done are registered. There is no combinational path from a, b or op to result.

## Structure
- Package muldiv_pkg holds:
  - the op encodings as localparams (OP_MUL … OP_REMU);
  - the state enum (IDLE, PREP, CALC, FIX, DONE);
  - WIDTH_DEFAULT = 32.
- No sub-module is needed. The multiply and divide datapaths share the counter and the sign-fix logic, and live in one module of roughly 250 lines.

## Test plan
- MUL, a=7, b=0xFFFFFFFD (−3) -> result 0xFFFFFFEB. done high only in cycle 35. stall high in cycles 0–34.
- Upper-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed vs unsigned divide:
  - DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU same operands -> 1.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - done in cycle 2, stall only in cycles 0–1.
- Overflow:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
  - done in cycle 2.
- Reset mid-operation:
  - rst_n=0 at cycle 10 of a DIVU -> next cycle IDLE, done=0, result=0, stall=0.
  - A fresh MULHU 0xFFFFFFFF × 2 then completes at its cycle 35 with result 1.
